rom_arbiter: RTL and testbench

Two-master access arbiter and sequencer for the single-port instruction ROM. It accepts read requests from an instruction-fetch master (m0) and a data/loader master (m1), grants them round-robin, and drives the ROM's chip-select/address-strobe handshake. It captures the ROM's read data and returns it to the granted master with a one-cycle ready pulse. It sits between the bus masters and `rom`, replacing the direct bus connection.

---
 rtl/rom_arbiter.sv | 168 ++++++++++++++++
 tb/tb_rom_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_arbiter.sv
// Round-robin two-master arbiter and strobe sequencer in front of the single-port instruction ROM.
// Optional WAIT timeout with bus_err reporting is compiled in when ROM_ARB_TIMEOUT_EN is defined.
module rom_arbiter #(
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_cs_,
  input  logic              m0_as_,
  input  logic [ADDR_W-1:0] m0_addr,
  output logic [DATA_W-1:0] m0_rd_data,
  output logic              m0_rdy_,
  input  logic              m1_cs_,
  input  logic              m1_as_,
  input  logic [ADDR_W-1:0] m1_addr,
  output logic [DATA_W-1:0] m1_rd_data,
  output logic              m1_rdy_,
  output logic              rom_cs_,
  output logic              rom_as_,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_rd_data,
  input  logic              rom_rdy_,
  output logic              bus_err
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t            state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic              strobe_q, strobe_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              m0_rdy_q, m0_rdy_d;
  logic              m1_rdy_q, m1_rdy_d;

  logic              m0_req;
  logic              m1_req;
  logic              pick;
  logic              timeout_hit;

  assign m0_req = ~m0_cs_ & ~m0_as_;
  assign m1_req = ~m1_cs_ & ~m1_as_;

  // Grant encoding: 0 selects m0, 1 selects m1; a tie goes to whoever lost last time.
  always_comb begin
    pick = 1'b0;
    if (m0_req && m1_req) begin
      pick = ~last_grant_q;
    end else if (m1_req) begin
      pick = 1'b1;
    end
  end

`ifdef ROM_ARB_TIMEOUT_EN
  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bus_err_q, bus_err_d;

  // The counter value is the number of WAIT cycles already completed.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ISSUE) begin
      cnt_d = '0;
    end else if (state_q == WAIT) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign timeout_hit = (state_q == WAIT) && rom_rdy_ && (cnt_q == CNT_LAST);
  assign bus_err_d   = timeout_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign bus_err = bus_err_q;
`else
  assign timeout_hit = 1'b0;
  assign bus_err     = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    strobe_d     = 1'b1;
    rom_addr_d   = rom_addr_q;
    data_d       = data_q;
    m0_rdy_d     = 1'b1;
    m1_rdy_d     = 1'b1;
    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          state_d      = ISSUE;
          grant_d      = pick;
          last_grant_d = pick;
          rom_addr_d   = pick ? m1_addr : m0_addr;
          strobe_d     = 1'b0;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        // A ready seen in the timeout cycle still delivers real data.
        if (!rom_rdy_ || timeout_hit) begin
          state_d  = RESP;
          data_d   = rom_rdy_ ? '0 : rom_rd_data;
          m0_rdy_d = grant_q;
          m1_rdy_d = ~grant_q;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      strobe_q     <= 1'b1;
      rom_addr_q   <= '0;
      data_q       <= '0;
      m0_rdy_q     <= 1'b1;
      m1_rdy_q     <= 1'b1;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      strobe_q     <= strobe_d;
      rom_addr_q   <= rom_addr_d;
      data_q       <= data_d;
      m0_rdy_q     <= m0_rdy_d;
      m1_rdy_q     <= m1_rdy_d;
    end
  end

  assign rom_cs_    = strobe_q;
  assign rom_as_    = strobe_q;
  assign rom_addr   = rom_addr_q;
  assign m0_rd_data = data_q;
  assign m1_rd_data = data_q;
  assign m0_rdy_    = m0_rdy_q;
  assign m1_rdy_    = m1_rdy_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Self-checking bench for rom_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model (grant cycle, strobe cycle, ROM latency and response cycle as arithmetic).
module tb_rom_arbiter;
  localparam int ADDR_W  = 11;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              reset;
  logic              m0_cs_, m0_as_, m1_cs_, m1_as_;
  logic [ADDR_W-1:0] m0_addr, m1_addr, rom_addr;
  logic [DATA_W-1:0] m0_rd_data, m1_rd_data, rom_rd_data;
  logic              m0_rdy_, m1_rdy_, rom_cs_, rom_as_, rom_rdy_, bus_err;

  always #5 clk = ~clk;

  rom_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .m0_cs_(m0_cs_), .m0_as_(m0_as_), .m0_addr(m0_addr), .m0_rd_data(m0_rd_data), .m0_rdy_(m0_rdy_),
    .m1_cs_(m1_cs_), .m1_as_(m1_as_), .m1_addr(m1_addr), .m1_rd_data(m1_rd_data), .m1_rdy_(m1_rdy_),
    .rom_cs_(rom_cs_), .rom_as_(rom_as_), .rom_addr(rom_addr),
    .rom_rd_data(rom_rd_data), .rom_rdy_(rom_rdy_), .bus_err(bus_err)
  );

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] rom_mem [1 << ADDR_W];

  // Model state: one outstanding transaction described by its key cycle numbers.
  int                cyc;
  bit                m_req    [2];
  logic [ADDR_W-1:0] m_addr   [2];
  int                m_gap    [2];
  int                m_policy [2];
  bit                m_done   [2];
  bit                have_t;
  int                t_master, t_strobe, t_lat, t_resp;
  logic [ADDR_W-1:0] t_addr;
  bit                t_err;
  int                next_idle;
  int                last_grant;
  logic [ADDR_W-1:0] exp_rom_addr;
  bit                reset_pending;
  int                lat_min, lat_max;
  bit                spurious_en;
  bit                exp_strobe, exp_err;
  bit                exp_rdy [2];
  logic [DATA_W-1:0] exp_data;

  int                strobe_cyc_q [$];
  logic [ADDR_W-1:0] strobe_addr_q [$];
  int                rdy_cyc_q [$];
  int                rdy_who_q [$];
  logic [DATA_W-1:0] rdy_data_q [$];
  int                err_cyc_q [$];

  int s;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic applyStimulus(input bit rst_in);
    int g;
    int w;
    if (reset_pending) begin
      have_t       = 1'b0;
      next_idle    = cyc;
      last_grant   = 1;
      exp_rom_addr = '0;
    end
    reset_pending = rst_in;

    for (int i = 0; i < 2; i++) begin
      if (!m_req[i] && m_gap[i] > 0) begin
        m_gap[i]--;
        if (m_gap[i] == 0) begin
          m_req[i]  = 1'b1;
          m_addr[i] = ADDR_W'($urandom);
        end
      end
      if (m_done[i]) begin
        m_done[i] = 1'b0;
        case (m_policy[i])
          1: m_req[i] = 1'b1;
          2: begin
            g         = int'($urandom_range(0, 2));
            m_addr[i] = ADDR_W'($urandom);
            if (g != 0) begin
              m_req[i] = 1'b0;
              m_gap[i] = g;
            end
          end
          default: m_req[i] = 1'b0;
        endcase
      end
    end

    reset = rst_in;
    if (m_req[0]) begin
      m0_cs_ = 1'b0; m0_as_ = 1'b0; m0_addr = m_addr[0];
    end else begin
      g = int'($urandom_range(1, 3));
      m0_cs_ = g[0]; m0_as_ = g[1]; m0_addr = ADDR_W'($urandom);
    end
    if (m_req[1]) begin
      m1_cs_ = 1'b0; m1_as_ = 1'b0; m1_addr = m_addr[1];
    end else begin
      g = int'($urandom_range(1, 3));
      m1_cs_ = g[0]; m1_as_ = g[1]; m1_addr = ADDR_W'($urandom);
    end

    if (!rst_in && cyc >= next_idle && (m_req[0] || m_req[1])) begin
      if (m_req[0] && m_req[1]) g = 1 - last_grant;
      else g = m_req[1] ? 1 : 0;
      last_grant = g;
      have_t     = 1'b1;
      t_master   = g;
      t_addr     = m_addr[g];
      t_strobe   = cyc + 1;
      t_lat      = int'($urandom_range(lat_min, lat_max));
`ifdef ROM_ARB_TIMEOUT_EN
      t_err = (t_lat > TIMEOUT);
      w     = t_err ? TIMEOUT : t_lat;
`else
      t_err = 1'b0;
      w     = t_lat;
`endif
      t_resp    = t_strobe + w + 1;
      next_idle = t_resp + 1;
    end

    rom_rd_data = DATA_W'($urandom);
    if (have_t && cyc > t_strobe && cyc < t_resp) begin
      rom_rdy_ = (cyc != t_strobe + t_lat);
      if (!rom_rdy_) rom_rd_data = rom_mem[t_addr];
    end else begin
      rom_rdy_ = spurious_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    exp_strobe = have_t && (cyc == t_strobe);
    if (exp_strobe) exp_rom_addr = t_addr;
    for (int i = 0; i < 2; i++) exp_rdy[i] = have_t && (cyc == t_resp) && (t_master == i);
    exp_err  = have_t && (cyc == t_resp) && t_err;
    exp_data = t_err ? '0 : rom_mem[t_addr];
    if (have_t && cyc == t_resp) m_done[t_master] = 1'b1;
  endtask

  task automatic checkCycle();
    checkOutput("rom_cs_", rom_cs_, !exp_strobe);
    checkOutput("rom_as_", rom_as_, !exp_strobe);
    checkOutput("rom_addr", rom_addr, exp_rom_addr);
    checkOutput("m0_rdy_", m0_rdy_, !exp_rdy[0]);
    checkOutput("m1_rdy_", m1_rdy_, !exp_rdy[1]);
    checkOutput("bus_err", bus_err, exp_err);
    if (exp_rdy[0]) checkOutput("m0_rd_data", m0_rd_data, exp_data);
    if (exp_rdy[1]) checkOutput("m1_rd_data", m1_rd_data, exp_data);
    if (rom_cs_ === 1'b0) begin
      strobe_cyc_q.push_back(cyc);
      strobe_addr_q.push_back(rom_addr);
    end
    if (m0_rdy_ === 1'b0) begin
      rdy_cyc_q.push_back(cyc); rdy_who_q.push_back(0); rdy_data_q.push_back(m0_rd_data);
    end
    if (m1_rdy_ === 1'b0) begin
      rdy_cyc_q.push_back(cyc); rdy_who_q.push_back(1); rdy_data_q.push_back(m1_rd_data);
    end
    if (bus_err === 1'b1) err_cyc_q.push_back(cyc);
  endtask

  task automatic runCycles(input int n, input bit rst_in);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      applyStimulus(rst_in);
      @(negedge clk);
      checkCycle();
      cyc++;
    end
  endtask

  task automatic clearLogs();
    strobe_cyc_q.delete(); strobe_addr_q.delete();
    rdy_cyc_q.delete(); rdy_who_q.delete(); rdy_data_q.delete(); err_cyc_q.delete();
  endtask

  function automatic int qInt(input int q [$], input int idx);
    return (q.size() > idx) ? q[idx] : -1;
  endfunction

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) rom_mem[i] = DATA_W'($urandom);
    rom_mem[5] = 32'hDEADBEEF;

    reset = 1'b1;
    m0_cs_ = 1'b1; m0_as_ = 1'b1; m0_addr = '0;
    m1_cs_ = 1'b1; m1_as_ = 1'b1; m1_addr = '0;
    rom_rdy_ = 1'b1; rom_rd_data = '0;
    cyc = 0; have_t = 1'b0; next_idle = 0; last_grant = 1; exp_rom_addr = '0;
    reset_pending = 1'b1; lat_min = 1; lat_max = 1; spurious_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_req[i] = 1'b0; m_addr[i] = '0; m_gap[i] = 0; m_policy[i] = 0; m_done[i] = 1'b0;
    end
    repeat (3) @(posedge clk);

    $display("[TB] reset and idle hold");
    runCycles(2, 1'b1);
    runCycles(10, 1'b0);
    checkOutput("reset_m0_data", m0_rd_data, 0);
    checkOutput("reset_m1_data", m1_rd_data, 0);

    $display("[TB] single m0 read");
    clearLogs();
    m_req[0] = 1'b1; m_addr[0] = 11'h005;
    s = cyc;
    runCycles(8, 1'b0);
    checkOutput("t2_strobe_count", strobe_cyc_q.size(), 1);
    checkOutput("t2_strobe_cycle", qInt(strobe_cyc_q, 0), s + 1);
    checkOutput("t2_strobe_addr", (strobe_addr_q.size() > 0) ? strobe_addr_q[0] : 11'h7FF, 11'h005);
    checkOutput("t2_rdy_count", rdy_cyc_q.size(), 1);
    checkOutput("t2_rdy_cycle", qInt(rdy_cyc_q, 0), s + 3);
    checkOutput("t2_rdy_master", qInt(rdy_who_q, 0), 0);
    checkOutput("t2_rdy_data", (rdy_data_q.size() > 0) ? rdy_data_q[0] : '0, 32'hDEADBEEF);

    $display("[TB] continuous contention");
    m_policy[0] = 1; m_policy[1] = 1;
    m_req[0] = 1'b1; m_addr[0] = 11'h010;
    m_req[1] = 1'b1; m_addr[1] = 11'h020;
    runCycles(1, 1'b1);
    clearLogs();
    s = cyc;
    runCycles(16, 1'b0);
    checkOutput("t3_strobe_count", strobe_cyc_q.size(), 4);
    checkOutput("t3_rdy_count", rdy_cyc_q.size(), 4);
    for (int j = 0; j < 4; j++) begin
      checkOutput("t3_strobe_cycle", qInt(strobe_cyc_q, j), s + 1 + 4 * j);
      checkOutput("t3_strobe_addr", (strobe_addr_q.size() > j) ? strobe_addr_q[j] : 11'h7FF,
                  (j % 2 == 0) ? 11'h010 : 11'h020);
      checkOutput("t3_rdy_cycle", qInt(rdy_cyc_q, j), s + 3 + 4 * j);
      checkOutput("t3_rdy_master", qInt(rdy_who_q, j), j % 2);
    end
    m_policy[0] = 0; m_policy[1] = 0;
    runCycles(10, 1'b0);

    $display("[TB] reset during m1 wait");
    clearLogs();
    lat_min = 3; lat_max = 3;
    m_req[1] = 1'b1; m_addr[1] = 11'h3A7;
    s = cyc;
    runCycles(2, 1'b0);
    runCycles(1, 1'b1);
    runCycles(1, 1'b0);
    checkOutput("t4_data_reset", m1_rd_data, 0);
    runCycles(8, 1'b0);
    checkOutput("t4_strobe_count", strobe_cyc_q.size(), 2);
    checkOutput("t4_restrobe_cycle", qInt(strobe_cyc_q, 1), s + 4);
    checkOutput("t4_rdy_count", rdy_cyc_q.size(), 1);
    checkOutput("t4_rdy_cycle", qInt(rdy_cyc_q, 0), s + 8);
    checkOutput("t4_rdy_master", qInt(rdy_who_q, 0), 1);
    checkOutput("t4_rdy_data", (rdy_data_q.size() > 0) ? rdy_data_q[0] : '0, rom_mem[11'h3A7]);

`ifdef ROM_ARB_TIMEOUT_EN
    $display("[TB] timeout with silent ROM");
    clearLogs();
    lat_min = 1000; lat_max = 1000;
    m_req[0] = 1'b1; m_addr[0] = 11'h123;
    s = cyc;
    runCycles(20, 1'b0);
    checkOutput("t5_rdy_count", rdy_cyc_q.size(), 1);
    checkOutput("t5_rdy_cycle", qInt(rdy_cyc_q, 0), s + 17);
    checkOutput("t5_rdy_data", (rdy_data_q.size() > 0) ? rdy_data_q[0] : 32'hFFFF_FFFF, 0);
    checkOutput("t5_err_count", err_cyc_q.size(), 1);
    checkOutput("t5_err_cycle", qInt(err_cyc_q, 0), s + 17);

    $display("[TB] ROM ready in the last wait cycle");
    clearLogs();
    lat_min = TIMEOUT; lat_max = TIMEOUT;
    m_req[0] = 1'b1; m_addr[0] = 11'h124;
    s = cyc;
    runCycles(20, 1'b0);
    checkOutput("t5b_rdy_cycle", qInt(rdy_cyc_q, 0), s + 17);
    checkOutput("t5b_rdy_data", (rdy_data_q.size() > 0) ? rdy_data_q[0] : '0, rom_mem[11'h124]);
    checkOutput("t5b_err_count", err_cyc_q.size(), 0);
`else
    $display("[TB] slow ROM without timeout");
    clearLogs();
    lat_min = 110; lat_max = 110;
    m_req[0] = 1'b1; m_addr[0] = 11'h123;
    s = cyc;
    runCycles(101, 1'b0);
    checkOutput("t5_no_rdy_100", rdy_cyc_q.size(), 0);
    runCycles(15, 1'b0);
    checkOutput("t5_rdy_count", rdy_cyc_q.size(), 1);
    checkOutput("t5_rdy_cycle", qInt(rdy_cyc_q, 0), s + 112);
    checkOutput("t5_rdy_data", (rdy_data_q.size() > 0) ? rdy_data_q[0] : '0, rom_mem[11'h123]);
    checkOutput("t5_err_count", err_cyc_q.size(), 0);
`endif

    $display("[TB] randomized traffic");
    m_policy[0] = 2; m_policy[1] = 2;
    m_req[0] = 1'b1; m_addr[0] = ADDR_W'($urandom);
    m_req[1] = 1'b1; m_addr[1] = ADDR_W'($urandom);
    lat_min = 1; lat_max = 4;
    spurious_en = 1'b1;
    for (int k = 0; k < 800; k++) runCycles(1, ($urandom_range(0, 99) == 0));
    m_policy[0] = 0; m_policy[1] = 0;
    spurious_en = 1'b0;
    runCycles(40, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
